// File: rtl/mux_4_1_rr_arbiter.sv
// rtl/mux_4_1_rr_arbiter.sv - 4-requester round-robin arbiter driving a 4:1 mux into a one-entry output register
// Optional build macro: MUX_ARB_FIXED_PRIO_EN (fixed priority 0>1>2>3 instead of round-robin)

module mux_4_1_rr_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [W-1:0] req_data_0,
    input  logic [W-1:0] req_data_1,
    input  logic [W-1:0] req_data_2,
    input  logic [W-1:0] req_data_3,
    output logic [3:0]   req_ready,
    output logic [1:0]   sel,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src,
    input  logic         out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [1:0]     out_src_q, out_src_d;
    logic [1:0]     ptr_q, ptr_d;

    logic           load_en;
    logic           any_req;
    logic           grant;
    logic [1:0]     winner;
    logic           found;
    logic [1:0]     idx;
    logic [W-1:0]   win_data;

    assign load_en = (state_q == EMPTY) || out_ready;
    assign any_req = |req_valid;
    assign grant   = load_en && any_req;

    // Search for the first valid requester, starting after the last winner
    // (or always at 0 in the fixed-priority build).
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            idx = 2'(k);
`else
            idx = ptr_q + 2'd1 + 2'(k);
`endif
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // 4:1 data mux; only the winning input reaches the register, so X on
    // the other inputs cannot leak into out_data.
    always_comb begin
        win_data = '0;
        case (winner)
            2'd0:    win_data = req_data_0;
            2'd1:    win_data = req_data_1;
            2'd2:    win_data = req_data_2;
            2'd3:    win_data = req_data_3;
            default: win_data = '0;
        endcase
    end

    // Next-state: load on grant, empty on an idle drain, otherwise hold.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        ptr_d      = ptr_q;
        if (load_en) begin
            if (any_req) begin
                state_d    = FULL;
                out_data_d = win_data;
                out_src_d  = winner;
                ptr_d      = winner;
            end else begin
                state_d    = EMPTY;
            end
        end
    end

    // Output register and round-robin pointer; pointer resets to 3 so
    // requester 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_src_q  <= 2'd0;
            ptr_q      <= 2'd3;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            ptr_q      <= ptr_d;
        end
    end

    // The register reads as EMPTY during reset, so rst gates req_ready
    // explicitly to keep requesters from seeing a grant while held in reset.
    assign req_ready = (grant && !rst) ? (4'b0001 << winner) : 4'b0000;
    assign sel       = any_req ? winner : ptr_q;
    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// tb/tb_mux_4_1_rr_arbiter.sv - randomized and directed bench for mux_4_1_rr_arbiter against a behavioural model

module tb_mux_4_1_rr_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [W-1:0] d [4];
    logic [3:0]   req_ready;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    int           m_ptr;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    logic [3:0]   last_ready;

    mux_4_1_rr_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data_0 (d[0]),
        .req_data_1 (d[1]),
        .req_data_2 (d[2]),
        .req_data_3 (d[3]),
        .req_ready  (req_ready),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_winner();
        int idx;
        for (int k = 0; k < 4; k++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (m_ptr + 1 + k) % 4;
`endif
            if (req_valid[idx] === 1'b1) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr   = 3;
        m_valid = 0;
        m_data  = '0;
        m_src   = 0;
    endtask

    // One clock: inputs already driven at the negedge. Check the
    // combinational grant, advance the model at the edge, check registers.
    task automatic step();
        int           w;
        bit           load;
        logic [3:0]   er;
        logic [W-1:0] wd;
        #1;
        load = !m_valid || out_ready;
        w    = model_winner();
        er   = (load && w >= 0) ? 4'(1 << w) : 4'b0000;
        wd   = (w >= 0) ? d[w] : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("sel", 32'(sel), (w >= 0) ? w : m_ptr);
        last_ready = er;
        @(posedge clk);
        if (load) begin
            if (w >= 0) begin
                m_valid = 1;
                m_data  = wd;
                m_src   = w;
                m_ptr   = w;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), m_src);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] pend;

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 'x;
        model_reset();
        @(negedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_out_src", 32'(out_src), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_sel", 32'(sel), 3);
        @(negedge clk);
        rst = 1'b0;

        // all four requesting: rotating grants, back-to-back
        req_valid = 4'b1111;
        out_ready = 1'b1;
        d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
        for (int i = 0; i < 8; i++) begin
            step();
`ifndef MUX_ARB_FIXED_PRIO_EN
            chk("fair_src", 32'(out_src), i % 4);
`else
            chk("fixed_src", 32'(out_src), 0);
`endif
        end
`ifdef MUX_ARB_FIXED_PRIO_EN
        req_valid = 4'b1110;
        step();
        chk("fixed_src_drop0", 32'(out_src), 1);
`endif

        // backpressure: load word from 0, then stall with 1 and 2 waiting
        async_reset();
        req_valid = 4'b0001;
        out_ready = 1'b1;
        step();
        req_valid = 4'b0110;
        d[0] = 'x;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        step();
        req_valid = 4'b0100;
        step();

        // single requester granted every cycle, then idle drain
        req_valid = 4'b0100;
        d[2] = 4'h7;
        for (int i = 0; i < 4; i++) step();
        req_valid = 4'b0000;
        d[2] = 'x;
        step();
        step();

        // wrap from ptr=3 with X on the idle inputs
        async_reset();
        req_valid = 4'b1001;
        d[0] = 4'h5; d[1] = 'x; d[2] = 'x; d[3] = 4'h9;
        for (int i = 0; i < 3; i++) step();

        // mid-stream reset, then lowest valid index wins
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
        step();
        async_reset();
        req_valid = 4'b0110;
        d[0] = 'x; d[3] = 'x;
        step();
        chk("post_rst_src", 32'(out_src), 1);

        // randomized: requesters hold until accepted, random backpressure
        pend = 4'b0000;
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) d[i] = 'x;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    d[i]    = 4'($urandom);
                end
            end
            req_valid = pend;
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            for (int i = 0; i < 4; i++) begin
                if (last_ready[i]) begin
                    pend[i] = 1'b0;
                    d[i]    = 'x;
                end
            end
            if (cyc == 300) begin
                async_reset();
                pend = 4'b0000;
                req_valid = 4'b0000;
                for (int i = 0; i < 4; i++) d[i] = 'x;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
